// File: rtl/input_port_requester_if.sv
// rtl/input_port_requester_if.sv - flit input, allocator request/grant and crossbar output bundle
interface input_port_requester_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  req;
    logic [2:0]            rout_port;
    logic [4:0]            grant_vec;
    logic [4:0]            out_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CW-1:0]         count;

    modport master (
        output in_valid, in_data, grant_vec, out_ready,
        input  in_ready, req, rout_port, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, grant_vec, out_ready,
        output in_ready, req, rout_port, out_valid, out_data, count
    );
endinterface

// File: rtl/input_port_requester.sv
// rtl/input_port_requester.sv - router input port: flit FIFO, XY route of head, allocator request FSM
module input_port_requester #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input_port_requester_if.slave  bus
);
    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CW    = PTR_W + 1;
    localparam logic [ADDR_W-1:0] CX    = ADDR_W'(CUR_X);
    localparam logic [ADDR_W-1:0] CY    = ADDR_W'(CUR_Y);
    localparam logic [CW-1:0]     FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SEND    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                state, state_nx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] head;
    logic [2:0]            head_port;

    logic                  req_r, req_nx;
    logic [2:0]            port_r, port_nx;
    logic                  ov_r, ov_nx;
    logic [DATA_WIDTH-1:0] od_r, od_nx;
    logic [4:0]            port_mask;
    logic                  fire;

    // Dimension-ordered routing: resolve x first, then y, else eject locally.
    function automatic logic [2:0] xy_route(input logic [DATA_WIDTH-1:0] flit);
        logic [ADDR_W-1:0] dx;
        logic [ADDR_W-1:0] dy;
        dx = flit[ADDR_W-1:0];
        dy = flit[2*ADDR_W-1:ADDR_W];
        if (dx > CX)      return 3'd3;
        else if (dx < CX) return 3'd1;
        else if (dy > CY) return 3'd4;
        else if (dy < CY) return 3'd2;
        else              return 3'd0;
    endfunction

    assign bus.in_ready = (count != FULL);
    assign push         = bus.in_valid && (count != FULL);
    assign head         = mem[rd_ptr];
    assign head_port    = xy_route(head);

    // Only the grant and ready bits of the frozen requested port matter.
    assign port_mask = 5'b00001 << port_r;
    assign fire      = (state == REQ) && (|(bus.grant_vec & bus.out_ready & port_mask));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            req_r  <= 1'b0;
            port_r <= 3'd0;
            ov_r   <= 1'b0;
            od_r   <= '0;
        end else begin
            state  <= state_nx;
            req_r  <= req_nx;
            port_r <= port_nx;
            ov_r   <= ov_nx;
            od_r   <= od_nx;
        end
    end

    always_comb begin
        state_nx = state;
        req_nx   = req_r;
        port_nx  = port_r;
        ov_nx    = 1'b0;
        od_nx    = od_r;
        pop      = 1'b0;
        case (state)
            IDLE, RELEASE: begin
                // Release behaves like idle so the allocator sees req low before the next request.
                req_nx = 1'b0;
                if (count != '0) begin
                    state_nx = REQ;
                    req_nx   = 1'b1;
                    port_nx  = head_port;
                end else begin
                    state_nx = IDLE;
                end
            end
            REQ: begin
                if (fire) begin
                    state_nx = SEND;
                    pop      = 1'b1;
                    req_nx   = 1'b0;
                    ov_nx    = 1'b1;
                    od_nx    = head;
                end
            end
            SEND: begin
                state_nx = RELEASE;
                req_nx   = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.req       = req_r;
    assign bus.rout_port = port_r;
    assign bus.out_valid = ov_r;
    assign bus.out_data  = od_r;
    assign bus.count     = count;
endmodule

// File: tb/tb_input_port_requester.sv
// tb/tb_input_port_requester.sv - bench for input_port_requester: vector table, corner sequences, random vs model
module tb_input_port_requester;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    input_port_requester_if #(.DATA_WIDTH(DW), .DEPTH(4)) ia ();
    input_port_requester_if #(.DATA_WIDTH(DW), .DEPTH(4)) ib ();

    input_port_requester #(.DATA_WIDTH(DW), .DEPTH(4), .ADDR_W(2), .CUR_X(1), .CUR_Y(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave));
    input_port_requester #(.DATA_WIDTH(DW), .DEPTH(4), .ADDR_W(2), .CUR_X(2), .CUR_Y(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] flit;
        int          port;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic int route_of(input logic [31:0] f, input int cx, input int cy);
        int x;
        int y;
        x = int'(f[1:0]);
        y = int'(f[3:2]);
        if (x > cx) return 3;
        if (x < cx) return 1;
        if (y > cy) return 4;
        if (y < cy) return 2;
        return 0;
    endfunction

    task automatic idle_inputs();
        ia.in_valid = 1'b0; ia.in_data = '0; ia.grant_vec = '0; ia.out_ready = '0;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.grant_vec = '0; ib.out_ready = '0;
    endtask

    task automatic push_to_req(input logic [31:0] f);
        ia.in_valid = 1'b1; ia.in_data = f; step();
        ia.in_valid = 1'b0; step();
    endtask

    vec_t        tbl[7];
    vec_t        tb5[4];
    logic [31:0] fl[5];
    logic [31:0] got[$];
    int          got_t[$];
    int          ports[$];
    logic [31:0] q[$];

    initial begin
        bit          m_req, m_ov, fire, n_req, vld, prev_req;
        logic [31:0] m_data, flit;
        logic [4:0]  gv, rdy;
        int          size0, p;

        tbl[0] = '{32'hCAFE_0007, 3};
        tbl[1] = '{32'h1234_0004, 1};
        tbl[2] = '{32'h0BAD_0001, 2};
        tbl[3] = '{32'hFFFF_FFFD, 4};
        tbl[4] = '{32'h5555_0005, 0};
        tbl[5] = '{32'h0000_000C, 1};
        tbl[6] = '{32'h8000_0002, 3};
        tb5[0] = '{32'h0000_000A, 0};
        tb5[1] = '{32'h0000_0002, 2};
        tb5[2] = '{32'h0000_000E, 4};
        tb5[3] = '{32'h0000_000C, 1};

        idle_inputs();
        #2;
        chk("rst_count", 32'(ia.count), 32'd0);
        chk("rst_in_ready", 32'(ia.in_ready), 32'd1);
        chk("rst_req", 32'(ia.req), 32'd0);
        chk("rst_port", 32'(ia.rout_port), 32'd0);
        chk("rst_valid", 32'(ia.out_valid), 32'd0);
        chk("rst_data", ia.out_data, 32'd0);
        step(); rst = 1'b1; step();

        // Route / single-flit timing table
        for (int i = 0; i < 7; i++) begin
            ia.in_valid = 1'b1; ia.in_data = tbl[i].flit; step();
            ia.in_valid = 1'b0;
            chk("tbl_count", 32'(ia.count), 32'd1);
            chk("tbl_req_early", 32'(ia.req), 32'd0);
            step();
            chk("tbl_req", 32'(ia.req), 32'd1);
            chk("tbl_port", 32'(ia.rout_port), 32'(tbl[i].port));
            ia.grant_vec = 5'(1 << tbl[i].port); ia.out_ready = 5'b11111; step();
            ia.grant_vec = '0; ia.out_ready = '0;
            chk("tbl_valid", 32'(ia.out_valid), 32'd1);
            chk("tbl_data", ia.out_data, tbl[i].flit);
            chk("tbl_req_send", 32'(ia.req), 32'd0);
            step();
            chk("tbl_valid_off", 32'(ia.out_valid), 32'd0);
            chk("tbl_req_release", 32'(ia.req), 32'd0);
            chk("tbl_data_hold", ia.out_data, tbl[i].flit);
            step();
        end

        // Stall: grant without downstream ready
        push_to_req(32'h0000_3307);
        ia.grant_vec = 5'b01000; ia.out_ready = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_req", 32'(ia.req), 32'd1);
            chk("stall_port", 32'(ia.rout_port), 32'd3);
            chk("stall_count", 32'(ia.count), 32'd1);
            chk("stall_valid", 32'(ia.out_valid), 32'd0);
        end
        ia.out_ready = 5'b01000; step();
        ia.grant_vec = '0; ia.out_ready = '0;
        chk("stall_deliver", 32'(ia.out_valid), 32'd1);
        chk("stall_data", ia.out_data, 32'h0000_3307);
        step(); step();

        // Wrong grant bit is ignored
        push_to_req(32'h0000_660D);
        chk("wg_port", 32'(ia.rout_port), 32'd4);
        ia.grant_vec = 5'b00010; ia.out_ready = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wg_valid", 32'(ia.out_valid), 32'd0);
            chk("wg_count", 32'(ia.count), 32'd1);
            chk("wg_req", 32'(ia.req), 32'd1);
        end
        ia.grant_vec = 5'b10000; step();
        ia.grant_vec = '0; ia.out_ready = '0;
        chk("wg_pop", 32'(ia.out_valid), 32'd1);
        chk("wg_data", ia.out_data, 32'h0000_660D);
        step(); step();

        // Full FIFO: fifth flit refused, then drained in order
        for (int i = 0; i < 5; i++) fl[i] = 32'h0000_0107 + 32'(i) * 32'h100;
        for (int i = 0; i < 5; i++) begin
            ia.in_valid = 1'b1; ia.in_data = fl[i]; step();
            if (i < 3) chk("full_ready_open", 32'(ia.in_ready), 32'd1);
            else       chk("full_ready_closed", 32'(ia.in_ready), 32'd0);
        end
        step();
        chk("full_count", 32'(ia.count), 32'd4);
        ia.in_valid = 1'b0; ia.grant_vec = 5'b11111; ia.out_ready = 5'b11111;
        got.delete(); got_t.delete();
        for (int c = 0; c < 40; c++) begin
            step();
            if (ia.out_valid) begin
                got.push_back(ia.out_data);
                got_t.push_back(c);
                chk("full_req_low_on_send", 32'(ia.req), 32'd0);
            end
        end
        chk("full_num_out", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) chk("full_order", got[i], fl[i]);
        for (int i = 1; i < got_t.size(); i++) chk("full_gap_ge3", 32'(got_t[i] - got_t[i-1] >= 3), 32'd1);
        chk("full_drained", 32'(ia.count), 32'd0);
        idle_inputs(); step();

        // Local/XY order on the (2,2) router
        for (int i = 0; i < 4; i++) begin
            ib.in_valid = 1'b1; ib.in_data = tb5[i].flit; step();
        end
        ib.in_valid = 1'b0; ib.grant_vec = 5'b11111; ib.out_ready = 5'b11111;
        prev_req = 1'b0; ports.delete();
        for (int c = 0; c < 40; c++) begin
            if (ib.req && !prev_req) ports.push_back(int'(ib.rout_port));
            prev_req = ib.req;
            step();
        end
        chk("xy_num_req", 32'(ports.size()), 32'd4);
        for (int i = 0; i < ports.size() && i < 4; i++) chk("xy_port", 32'(ports[i]), 32'(tb5[i].port));
        idle_inputs(); step();

        // Asynchronous reset in the middle of a request
        push_to_req(32'h0000_0007);
        chk("areset_pre_req", 32'(ia.req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("areset_req", 32'(ia.req), 32'd0);
        chk("areset_valid", 32'(ia.out_valid), 32'd0);
        chk("areset_count", 32'(ia.count), 32'd0);
        chk("areset_in_ready", 32'(ia.in_ready), 32'd1);
        step(); rst = 1'b1; step(); step();
        chk("areset_flit_lost", 32'(ia.req), 32'd0);

        // Random traffic against a queue-level model
        q.delete(); m_req = 0; m_ov = 0; m_data = '0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_count", 32'(ia.count), 32'(q.size()));
            chk("rnd_in_ready", 32'(ia.in_ready), 32'(q.size() != 4));
            chk("rnd_req", 32'(ia.req), 32'(m_req));
            chk("rnd_valid", 32'(ia.out_valid), 32'(m_ov));
            chk("rnd_data", ia.out_data, m_data);
            if (m_req) chk("rnd_port", 32'(ia.rout_port), 32'(route_of(q[0], 1, 1)));
            vld  = 1'($urandom_range(0, 1));
            flit = $urandom;
            gv   = 5'($urandom);
            rdy  = 5'($urandom);
            ia.in_valid = vld; ia.in_data = flit; ia.grant_vec = gv; ia.out_ready = rdy;
            size0 = q.size();
            p     = m_req ? route_of(q[0], 1, 1) : 0;
            fire  = m_req && gv[p] && rdy[p];
            n_req = m_req ? !fire : (!m_ov && size0 > 0);
            if (fire) m_data = q.pop_front();
            if (vld && size0 != 4) q.push_back(flit);
            m_ov  = fire;
            m_req = n_req;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
